// File: rtl/rand_matrix_stream_if.sv
// Element stream bundle for rand_matrix_stream.
//
// Handshake: the master raises out_valid with a payload (data_out, out_row,
// out_col, out_mat, out_last_elem, out_last). The payload is transferred on a
// rising clk edge where out_valid && out_ready are both high. While out_valid
// is high and out_ready is low, every payload field is held stable. out_valid
// never depends combinationally on out_ready.
//
// Ports (master view):
//   data_out      out  signed element value
//   out_valid     out  payload present
//   out_ready     in   sink can accept
//   out_row/col   out  0-based element coordinates
//   out_mat       out  0-based matrix index
//   out_last_elem out  last element of the current matrix
//   out_last      out  last element of the last matrix
interface rand_matrix_stream_if #(
  parameter int DATA_W = 8,
  parameter int DIM_W  = 3,
  parameter int CNT_W  = 4
);
  logic signed [DATA_W-1:0] data_out;
  logic                     out_valid;
  logic                     out_ready;
  logic [DIM_W-1:0]         out_row;
  logic [DIM_W-1:0]         out_col;
  logic [CNT_W-1:0]         out_mat;
  logic                     out_last_elem;
  logic                     out_last;

  modport master (
    output data_out, out_valid, out_row, out_col, out_mat, out_last_elem, out_last,
    input  out_ready
  );

  modport slave (
    input  data_out, out_valid, out_row, out_col, out_mat, out_last_elem, out_last,
    output out_ready
  );
endinterface

// File: rtl/rand_matrix_stream.sv
// rand_matrix_stream: streams `count` matrices of dim_m x dim_n signed
// elements, row-major, one element per accepted handshake. Element values
// come from a seedable 16-bit Fibonacci LFSR (uniform / random-diagonal
// modes) or are fixed patterns (constant / identity).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   elem_min_cfg/max    signed inclusive bounds for random values
//   mode                0 uniform, 1 constant(min), 2 identity, 3 random diag
//   seed, seed_load     LFSR seed load (honoured only while idle)
//   start_gen           start request (honoured only while idle)
//   abort               cancel an active generation
//   dim_m, dim_n, count matrix rows, cols and number of matrices
//   out_if              element stream (master side)
//   busy                generator not idle
//   gen_done            one-cycle pulse after the final element is taken
//   cfg_err             one-cycle pulse after a rejected start
//   state_dbg           current FSM state encoding
module rand_matrix_stream #(
  parameter int DATA_W = 8,
  parameter int DIM_W  = 3,
  parameter int CNT_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] elem_min_cfg,
  input  logic signed [DATA_W-1:0] elem_max_cfg,
  input  logic [1:0]               mode,
  input  logic [15:0]              seed,
  input  logic                     seed_load,
  input  logic                     start_gen,
  input  logic                     abort,
  input  logic [DIM_W-1:0]         dim_m,
  input  logic [DIM_W-1:0]         dim_n,
  input  logic [CNT_W-1:0]         count,
  rand_matrix_stream_if.master     out_if,
  output logic                     busy,
  output logic                     gen_done,
  output logic                     cfg_err,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [15:0]      LFSR_INIT = 16'hACE1;
  localparam logic [DIM_W-1:0] DIM_ONE   = 1;
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;

  state_t                   state_q, state_d;
  logic [15:0]              lfsr_q;
  logic [DIM_W-1:0]         m_q, n_q, row_q, col_q;
  logic [CNT_W-1:0]         cnt_q, mat_q;
  logic [1:0]               mode_q;
  logic signed [DATA_W-1:0] min_q, max_q;
  logic                     cfg_err_q;

  logic cfg_bad, start_req, handshake, last_col, last_row, last_elem, last_mat;

  // Abort outranks start, so a start coinciding with abort is dropped.
  assign cfg_bad   = (dim_m == '0) || (dim_n == '0) || (count == '0) ||
                     (elem_min_cfg > elem_max_cfg);
  assign start_req = (state_q == S_IDLE) && start_gen && !abort;
  assign handshake = (state_q == S_EMIT) && out_if.out_ready && !abort;
  assign last_col  = (col_q == n_q - DIM_ONE);
  assign last_row  = (row_q == m_q - DIM_ONE);
  assign last_elem = last_col && last_row;
  assign last_mat  = (mat_q == cnt_q - CNT_ONE);

  // Element value. The range is formed one bit wider than the data so that
  // the full signed span (e.g. -128..127 -> 256) is representable.
  logic signed [DATA_W:0]   min_x, max_x, rand_x;
  logic [DATA_W:0]          range_u, rem_u;
  logic [16:0]              rem_full;
  logic signed [DATA_W-1:0] elem_val;
  logic                     diag;

  always_comb begin
    min_x    = {min_q[DATA_W-1], min_q};
    max_x    = {max_q[DATA_W-1], max_q};
    range_u  = max_x - min_x + {{DATA_W{1'b0}}, 1'b1};
    rem_full = {1'b0, lfsr_q} % 17'(range_u);
    rem_u    = rem_full[DATA_W:0];
    // rem_u < range <= 2^DATA_W, so its top bit is clear and it is non-negative.
    rand_x   = min_x + $signed(rem_u);
    diag     = (row_q == col_q);
    elem_val = '0;
    case (mode_q)
      2'd0:    elem_val = rand_x[DATA_W-1:0];
      2'd1:    elem_val = min_q;
      2'd2:    elem_val = diag ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      default: elem_val = diag ? rand_x[DATA_W-1:0] : '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_req && !cfg_bad) state_d = S_EMIT;
      S_EMIT: begin
        if (abort)                                     state_d = S_IDLE;
        else if (handshake && last_elem && last_mat)   state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_INIT;
      m_q       <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      mat_q     <= '0;
      mode_q    <= '0;
      min_q     <= '0;
      max_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= start_req && cfg_bad;

      if (start_req && !cfg_bad) begin
        m_q    <= dim_m;
        n_q    <= dim_n;
        cnt_q  <= count;
        mode_q <= mode;
        min_q  <= elem_min_cfg;
        max_q  <= elem_max_cfg;
        row_q  <= '0;
        col_q  <= '0;
        mat_q  <= '0;
      end

      if (state_q == S_IDLE && seed_load) begin
        lfsr_q <= (seed == 16'h0000) ? LFSR_INIT : seed;
      end else if (handshake) begin
        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        // Coordinates stay on the final element once the stream completes.
        if (!(last_elem && last_mat)) begin
          if (last_col) begin
            col_q <= '0;
            if (last_row) begin
              row_q <= '0;
              mat_q <= mat_q + CNT_ONE;
            end else begin
              row_q <= row_q + DIM_ONE;
            end
          end else begin
            col_q <= col_q + DIM_ONE;
          end
        end
      end
    end
  end

  assign out_if.out_valid     = (state_q == S_EMIT);
  assign out_if.data_out      = out_if.out_valid ? elem_val : '0;
  assign out_if.out_row       = row_q;
  assign out_if.out_col       = col_q;
  assign out_if.out_mat       = mat_q;
  assign out_if.out_last_elem = out_if.out_valid && last_elem;
  assign out_if.out_last      = out_if.out_valid && last_elem && last_mat;

  assign busy      = (state_q != S_IDLE);
  assign gen_done  = (state_q == S_DONE);
  assign cfg_err   = cfg_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rand_matrix_stream.sv
// Bench for rand_matrix_stream: directed scenarios, a reference model that
// expands each generation into its full element list, and a compare process
// that checks the stream on every cycle an element is presented.
module tb_rand_matrix_stream;
  localparam int DW = 8;
  localparam int MW = 3;
  localparam int CW = 4;
  localparam int W  = 20;  // {data, row, col, mat, last_elem, last}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DW-1:0] elem_min_cfg = '0, elem_max_cfg = '0;
  logic [1:0]           mode = '0;
  logic [15:0]          seed = '0;
  logic                 seed_load = 1'b0, start_gen = 1'b0, abort = 1'b0;
  logic [MW-1:0]        dim_m = '0, dim_n = '0;
  logic [CW-1:0]        count = '0;
  logic                 busy, gen_done, cfg_err;
  logic [1:0]           state_dbg;

  rand_matrix_stream_if #(.DATA_W(DW), .DIM_W(MW), .CNT_W(CW)) sif ();

  rand_matrix_stream #(.DATA_W(DW), .DIM_W(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .elem_min_cfg(elem_min_cfg), .elem_max_cfg(elem_max_cfg),
    .mode(mode), .seed(seed), .seed_load(seed_load),
    .start_gen(start_gen), .abort(abort),
    .dim_m(dim_m), .dim_n(dim_n), .count(count),
    .out_if(sif),
    .busy(busy), .gen_done(gen_done), .cfg_err(cfg_err),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] got_q[$];
  int            cyc_q[$];
  int acc_cnt = 0, le_cnt = 0, l_cnt = 0, done_cnt = 0;
  logic [15:0] tb_lfsr = 16'hACE1;
  logic        exp_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [W-1:0] pack(input logic [DW-1:0] d, input logic [MW-1:0] r,
                                        input logic [MW-1:0] c, input logic [CW-1:0] m,
                                        input logic le, input logic l);
    return {d, r, c, m, le, l};
  endfunction

  // Model: enumerate every element of the generation in scan order with
  // plain integer arithmetic, starting from the current LFSR value.
  task automatic expect_gen(input int mn, input int mx, input int md,
                            input int m, input int n, input int c);
    logic [15:0] l;
    int v, rv;
    l = tb_lfsr;
    for (int k = 0; k < c; k++)
      for (int r = 0; r < m; r++)
        for (int q = 0; q < n; q++) begin
          rv = mn + (int'(l) % (mx - mn + 1));
          case (md)
            0:       v = rv;
            1:       v = mn;
            2:       v = (r == q) ? 1 : 0;
            default: v = (r == q) ? rv : 0;
          endcase
          exp_q.push_back(pack(8'(v), 3'(r), 3'(q), 4'(k),
                               (r == m-1) && (q == n-1),
                               (r == m-1) && (q == n-1) && (k == c-1)));
          l = lfsr_step(l);
        end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      exp_done = 1'b0;
    end else begin
      chk("gen_done", 32'(gen_done), 32'(exp_done));
      if (exp_done) chk("valid_in_done", 32'(sif.out_valid), 32'd0);
      if (gen_done) done_cnt++;
      exp_done = 1'b0;
      if (sif.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_elem", 32'd1, 32'd0);
        end else begin
          chk("elem", 32'(pack(sif.data_out, sif.out_row, sif.out_col, sif.out_mat,
                               sif.out_last_elem, sif.out_last)), 32'(exp_q[0]));
          if (sif.out_ready && !abort) begin
            e = exp_q.pop_front();
            tb_lfsr = lfsr_step(tb_lfsr);
            got_q.push_back(sif.data_out);
            cyc_q.push_back(cyc);
            acc_cnt++;
            le_cnt += int'(e[1]);
            l_cnt  += int'(e[0]);
            if (e[0]) exp_done = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input int mn, input int mx, input int md,
                         input int m, input int n, input int c);
    elem_min_cfg = 8'(mn);
    elem_max_cfg = 8'(mx);
    mode  = 2'(md);
    dim_m = 3'(m);
    dim_n = 3'(n);
    count = 4'(c);
  endtask

  task automatic go(input int mn, input int mx, input int md,
                    input int m, input int n, input int c);
    set_cfg(mn, mx, md, m, n, c);
    expect_gen(mn, mx, md, m, n, c);
    @(posedge clk); #1 start_gen = 1'b1;
    @(posedge clk); #1 start_gen = 1'b0;
  endtask

  task automatic do_seed(input logic [15:0] s);
    @(posedge clk); #1 seed = s; seed_load = 1'b1;
    @(posedge clk); #1 seed_load = 1'b0;
    tb_lfsr = (s == 16'h0000) ? 16'hACE1 : s;
  endtask

  task automatic wait_done();
    int d0, g;
    d0 = done_cnt;
    g  = 0;
    while (done_cnt == d0 && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    chk("done_seen", 32'(done_cnt != d0), 32'd1);
    chk("exp_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic bad_start(input int mn, input int mx, input int m, input int n, input int c);
    set_cfg(mn, mx, 0, m, n, c);
    @(posedge clk); #1 start_gen = 1'b1;
    @(posedge clk); #1 start_gen = 1'b0;
    @(negedge clk);
    chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
    chk("cfg_err_busy", 32'(busy), 32'd0);
    chk("cfg_err_valid", 32'(sif.out_valid), 32'd0);
    @(negedge clk);
    chk("cfg_err_drop", 32'(cfg_err), 32'd0);
    chk("cfg_err_busy2", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_data"}, 32'(sif.data_out), 32'd0);
    chk({tag, "_valid"}, 32'(sif.out_valid), 32'd0);
    chk({tag, "_coord"}, 32'({sif.out_row, sif.out_col, sif.out_mat}), 32'd0);
    chk({tag, "_lasts"}, 32'({sif.out_last_elem, sif.out_last}), 32'd0);
    chk({tag, "_flags"}, 32'({busy, gen_done, cfg_err}), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  logic [DW-1:0] seq1[$];
  int a0, le0, l0;

  initial begin
    sif.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_reset_outs("reset");
    rst = 1'b0;

    // Uniform random, -3..3, 2x2, one matrix.
    a0 = acc_cnt; le0 = le_cnt; l0 = l_cnt;
    go(-3, 3, 0, 2, 2, 1);
    wait_done();
    chk("t1_count", 32'(acc_cnt - a0), 32'd4);
    chk("t1_first", 32'(got_q[a0]), 32'h00);
    chk("t1_second", 32'(got_q[a0+1]), 32'h02);
    chk("t1_last", 32'(l_cnt - l0), 32'd1);
    for (int i = 0; i < 4; i++) seq1.push_back(got_q[a0+i]);

    // Same generation with a 5-cycle stall on element 1.
    do_seed(16'h0000);
    a0 = acc_cnt;
    sif.out_ready = 1'b0;
    go(-3, 3, 0, 2, 2, 1);
    sif.out_ready = 1'b1;
    @(posedge clk); #1 sif.out_ready = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    sif.out_ready = 1'b1;
    wait_done();
    for (int i = 0; i < 4; i++) chk("bp_same_seq", 32'(got_q[a0+i]), 32'(seq1[i]));

    // Identity, 3x3, two matrices back to back.
    a0 = acc_cnt; le0 = le_cnt; l0 = l_cnt;
    go(-3, 3, 2, 3, 3, 2);
    wait_done();
    chk("id_count", 32'(acc_cnt - a0), 32'd18);
    chk("id_last_elem", 32'(le_cnt - le0), 32'd2);
    chk("id_last", 32'(l_cnt - l0), 32'd1);
    if (cyc_q.size() >= a0 + 18) chk("id_no_bubble", 32'(cyc_q[a0+17] - cyc_q[a0]), 32'd17);
    else chk("id_no_bubble", 32'(cyc_q.size()), 32'(a0 + 18));

    // Rejected starts.
    bad_start(5, -5, 2, 2, 1);
    bad_start(-3, 3, 2, 0, 1);
    bad_start(-3, 3, 2, 2, 0);

    // Abort while element 3 of a 4x4 is presented.
    a0 = acc_cnt;
    go(-3, 3, 0, 4, 4, 1);
    for (int g = 0; g < 50 && acc_cnt - a0 < 3; g++) begin @(posedge clk); #1; end
    chk("ab_reached", 32'(acc_cnt - a0), 32'd3);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("ab_valid", 32'(sif.out_valid), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_accepted", 32'(acc_cnt - a0), 32'd3);
    exp_q.delete();
    go(-3, 3, 0, 2, 2, 1);
    wait_done();

    // Seeds: 0 behaves as ACE1, 0x1234 gives -76, load while busy ignored.
    a0 = acc_cnt;
    do_seed(16'h0000);
    go(-3, 3, 0, 1, 1, 1);
    wait_done();
    chk("seed0_val", 32'(got_q[a0]), 32'h00);
    do_seed(16'h1234);
    go(-128, 127, 0, 1, 1, 1);
    wait_done();
    chk("seed1234_val", 32'(got_q[a0+1]), 32'hB4);
    sif.out_ready = 1'b0;
    go(-128, 127, 0, 2, 2, 1);
    @(posedge clk); #1 seed = 16'h0001; seed_load = 1'b1;
    @(posedge clk); #1 seed_load = 1'b0;
    sif.out_ready = 1'b1;
    wait_done();
    chk("seed_busy_val", 32'(got_q[a0+2]), 32'hE9);

    // Synchronous reset mid-stream.
    go(-3, 3, 0, 4, 4, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 chk_reset_outs("midrst");
    rst = 1'b0;
    exp_q.delete();
    tb_lfsr = 16'hACE1;
    a0 = acc_cnt;
    go(-3, 3, 0, 1, 1, 1);
    wait_done();
    chk("midrst_lfsr", 32'(got_q[a0]), 32'h00);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/rand_matrix_stream.md
# rand_matrix_stream

Parametrised random-matrix source that streams `count` matrices of `dim_m × dim_n` signed elements over a valid/ready interface. It feeds the matrix storage/compute path. Compared with the earlier generator it adds generic element width and dimension range, a seedable deterministic LFSR, fill modes, per-element coordinates, output backpressure, abort, and configuration-error reporting.

## Interface
- `DATA_W`, 8: element width, signed, legal 2..16.
- `DIM_W`, 3: dimension field width; legal dimensions are 1..2^DIM_W−1.
- `CNT_W`, 4: matrix-count field width.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: reset; one clock, synchronous, active-high.
- `elem_min_cfg` in DATA_W: signed lower bound, inclusive.
- `elem_max_cfg` in DATA_W: signed upper bound, inclusive.
- `mode` in 2: 0 uniform random, 1 constant (`elem_min_cfg`), 2 identity, 3 random diagonal.
- `seed` in 16: LFSR seed.
- `seed_load` in 1: load `seed` (IDLE only).
- `start_gen` in 1: start request (IDLE only).
- `abort` in 1: cancel generation.
- `dim_m`, `dim_n` in DIM_W: rows, cols.
- `count` in CNT_W: number of matrices.
- `data_out` out DATA_W: element.
- `out_valid` out 1 / `out_ready` in 1: element handshake.
- `out_row`, `out_col` out DIM_W: element coordinates, 0-based.
- `out_mat` out CNT_W: matrix index, 0-based.
- `out_last_elem` out 1: last element of current matrix.
- `out_last` out 1: last element of last matrix.
- `busy` out 1: state ≠ IDLE.
- `gen_done` out 1: one-cycle completion pulse.
- `cfg_err` out 1: one-cycle rejected-start pulse.

## Operation
- States:
  - IDLE: waiting for `start_gen`.
  - EMIT: streaming elements.
  - DONE: single cycle; pulses `gen_done`, then returns to IDLE.
- Start handling: in IDLE, `start_gen` latches `dim_m`, `dim_n`, `count`, `mode` and the bounds.
  - Reject, and pulse `cfg_err` next cycle staying IDLE, if any of: `dim_m==0`, `dim_n==0`, `count==0`, or `elem_min_cfg > elem_max_cfg` (signed compare).
  - Otherwise go to EMIT with row/col/mat = 0.
- Scan order: row-major; col increments fastest; mat increments after `(dim_m−1, dim_n−1)`. There is no bubble between matrices.
- LFSR: 16-bit, next = `{l[14:0], l[15]^l[13]^l[12]^l[10]}`.
  - Reset value is 16'hACE1.
  - `seed_load` in IDLE loads `seed`; seed 0 loads 16'hACE1.
  - `seed_load` outside IDLE is ignored.
  - The LFSR advances exactly once per accepted element (`out_valid && out_ready`), in every mode, and never otherwise.
- Element value at the current LFSR `l`:
  - Random: `range = max − min + 1`, computed unsigned at DATA_W+1 bits. Value = `min + (l % range)`, computed at DATA_W+1 bits signed and truncated to DATA_W; it always lies in [min, max].
  - Mode 0: random value.
  - Mode 1: `elem_min_cfg`.
  - Mode 2: 1 if row==col, else 0.
  - Mode 3: random value if row==col, else 0.
- Abort: `abort` in any non-IDLE state moves to IDLE next cycle, drops `out_valid`, and does not pulse `gen_done`. The LFSR keeps its value.
- Priority: `rst` > `abort` > handshake/start. `start_gen` while busy is ignored.

## Timing
- Reset values: `data_out`=0, `out_valid`=0, `out_row`=`out_col`=`out_mat`=0, `out_last_elem`=`out_last`=0, `busy`=0, `gen_done`=0, `cfg_err`=0. LFSR = ACE1.
- Start latency: `start_gen` accepted at edge N gives `out_valid`=1 with element (0,0,0) registered at edge N+1.
- Backpressure: while `out_valid && !out_ready`, all `out_*` and `data_out` are held stable.
- Throughput: one element per cycle while `out_ready`=1.
- Completion: the handshake of the element with `out_last`=1 at edge K moves to DONE. `out_valid`=0 and `gen_done`=1 during cycle K+1; IDLE at K+2, when a new `start_gen` is accepted.
- `cfg_err` is high during the cycle after the rejected start.
- Synchronous `rst` mid-stream returns every output to its reset value at the next edge.

## Test plan
- Uniform random after reset, min=−3, max=3, 2×2, count=1, `out_ready`=1:
  - first `data_out`=0 (0xACE1%7=3), second=2 (0x59C3%7=5);
  - 4 elements, `out_last` on (1,1,0), `gen_done` one cycle later.
- Backpressure: hold `out_ready`=0 for 5 cycles on element 1 → `data_out`, `out_row`, `out_col` and the LFSR all unchanged, and the element sequence is identical to the previous test.
- Identity, 3×3, count=2 → 18 elements; 1 only at row==col; `out_mat` goes 0→1 with no bubble; `out_last_elem` fires twice; `out_last` fires once.
- Config error:
  - min=5, max=−5 → `cfg_err` pulse, no `out_valid`, `busy`=0;
  - repeat with `dim_n`=0 and `count`=0 → same response.
- Abort at element 3 of a 4×4 generation → `out_valid`=0 and `busy`=0 next cycle, no `gen_done`; a fresh start then begins at (0,0,0).
- Seed: `seed_load` with 0x0000 → first element behaves as ACE1; `seed_load` with 0x1234 → first mode-0 value (range 256, min=−128) = −128+0x34 = −76. `seed_load` while busy has no effect.
